// File: rtl/audio_codec_cfg_seq_if.sv
// audio_codec_cfg_seq_if
//   Bundles the I2C_Command engine bus and the runtime register-write
//   requester port of the audio codec configuration sequencer.
//   master : sequencer side (drives engine command, usr_ack)
//   slave  : engine/requester side (drives free, usr_req/reg/data)
//
//   i2c_slave_addr [7:0]  codec address byte to engine
//   i2c_register   [7:0]  register byte to engine
//   i2c_data       [7:0]  data byte to engine
//   i2c_enable            one-cycle start-of-write pulse to engine
//   i2c_free              engine idle flag (high = bus idle)
//   usr_req               runtime write request, level until usr_ack
//   usr_reg        [7:0]  runtime register byte
//   usr_data       [7:0]  runtime data byte
//   usr_ack               one-cycle completion pulse for the runtime write
interface audio_codec_cfg_seq_if;
  logic [7:0] i2c_slave_addr;
  logic [7:0] i2c_register;
  logic [7:0] i2c_data;
  logic       i2c_enable;
  logic       i2c_free;
  logic       usr_req;
  logic [7:0] usr_reg;
  logic [7:0] usr_data;
  logic       usr_ack;

  modport master (
    output i2c_slave_addr, i2c_register, i2c_data, i2c_enable, usr_ack,
    input  i2c_free, usr_req, usr_reg, usr_data
  );

  modport slave (
    input  i2c_slave_addr, i2c_register, i2c_data, i2c_enable, usr_ack,
    output i2c_free, usr_req, usr_reg, usr_data
  );
endinterface

// File: rtl/audio_codec_cfg_seq.sv
// audio_codec_cfg_seq
//   Owns the audio-path I2C_Command engine. After reset or a start pulse it
//   waits for codec power to settle, then writes a fixed table of codec
//   registers, one engine write per entry paced on the engine free flag.
//   Once the table is done it serves a single runtime write requester.
//
//   i_sys_clk         system clock
//   i_reset           synchronous, active-high reset
//   i_start           one-cycle pulse, restarts table from entry 0 (ignored while busy)
//   bus (master)      engine command bus and runtime requester handshake
//   o_busy            high in any state except IDLE, DONE, ERROR
//   o_done            high in DONE
//   o_error           high in ERROR (sticky until start)
//   o_entry_idx [3:0] current table index
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | safe landing for illegal encodings, waits for start
//   PWR_WAIT   | codec power-settle delay before the first write
//   LOAD       | latch register/data, hold until engine is free
//   ISSUE      | one-cycle enable pulse to the engine
//   WAIT_BUSY  | wait for engine to accept (free low), ack timeout
//   WAIT_FREE  | wait for transfer end (free high), transfer timeout
//   GAP        | idle spacing before next write / completion
//   DONE       | table complete, serves runtime writes
//   ERROR      | engine timeout, sticky until start
module audio_codec_cfg_seq #(
  parameter logic [7:0] SLAVE_ADDR   = 8'h35,
  parameter int         NUM_ENTRIES  = 6,
  parameter int         STARTUP_DLY  = 1000,
  parameter int         ACK_TIMEOUT  = 16,
  parameter int         XFER_TIMEOUT = 65535,
  parameter int         GAP_CYCLES   = 8
) (
  input  logic                 i_sys_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  audio_codec_cfg_seq_if.master bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [3:0]           o_entry_idx
);

  localparam int MAX_AB = (STARTUP_DLY > ACK_TIMEOUT) ? STARTUP_DLY : ACK_TIMEOUT;
  localparam int MAX_CD = (XFER_TIMEOUT > GAP_CYCLES) ? XFER_TIMEOUT : GAP_CYCLES;
  localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  // The enable cycle itself counts toward the ack timeout, so WAIT_BUSY
  // gives up one count earlier than the other waits.
  localparam logic [CNT_W-1:0] C_PWR_LAST  = CNT_W'(STARTUP_DLY - 1);
  localparam logic [CNT_W-1:0] C_ACK_LAST  = CNT_W'((ACK_TIMEOUT >= 2) ? ACK_TIMEOUT - 2 : 0);
  localparam logic [CNT_W-1:0] C_XFER_LAST = CNT_W'(XFER_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       C_IDX_LAST  = 4'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_LOAD, S_ISSUE, S_WAIT_BUSY,
    S_WAIT_FREE, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_idx;
  logic [3:0]       w_idx_nxt;
  logic             r_user;
  logic             w_user_nxt;
  logic [7:0]       r_reg;
  logic [7:0]       r_data;
  logic             w_load;
  logic             w_enable;
  logic             w_ack;
  logic             w_cnt_clr;
  logic [15:0]      w_rom;

  function automatic logic [15:0] f_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    f_rom = {8'h1E, 8'h00};
      4'd1:    f_rom = {8'h0C, 8'h00};
      4'd2:    f_rom = {8'h0E, 8'h0A};
      4'd3:    f_rom = {8'h10, 8'h00};
      4'd4:    f_rom = {8'h0A, 8'h00};
      4'd5:    f_rom = {8'h12, 8'h01};
      default: f_rom = 16'h0000;
    endcase
  endfunction

  assign w_rom = f_rom(r_idx);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_user_nxt  = r_user;
    w_load      = 1'b0;
    w_enable    = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_idx_nxt   = 4'd0;
          w_user_nxt  = 1'b0;
          w_state_nxt = S_PWR_WAIT;
        end
      end
      S_PWR_WAIT: begin
        if (r_cnt >= C_PWR_LAST) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_load = 1'b1;
        if (bus.i2c_free) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_enable    = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!bus.i2c_free)           w_state_nxt = S_WAIT_FREE;
        else if (r_cnt >= C_ACK_LAST) w_state_nxt = S_ERROR;
      end
      S_WAIT_FREE: begin
        if (bus.i2c_free)              w_state_nxt = S_GAP;
        else if (r_cnt >= C_XFER_LAST) w_state_nxt = S_ERROR;
      end
      S_GAP: begin
        if (r_cnt >= C_GAP_LAST) begin
          if (r_user) begin
            w_ack       = 1'b1;
            w_user_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else if (r_idx < C_IDX_LAST) begin
            w_idx_nxt   = r_idx + 4'd1;
            w_state_nxt = S_LOAD;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // start outranks a simultaneous request; the request stays pending
        if (i_start) begin
          w_idx_nxt   = 4'd0;
          w_state_nxt = S_PWR_WAIT;
        end else if (bus.usr_req) begin
          w_user_nxt  = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_ERROR: begin
        if (i_start) begin
          w_idx_nxt   = 4'd0;
          w_user_nxt  = 1'b0;
          w_state_nxt = S_PWR_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Every state entry restarts the shared cycle counter.
  assign w_cnt_clr = (w_state_nxt != r_state);

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state <= S_PWR_WAIT;
      r_cnt   <= '0;
      r_idx   <= 4'd0;
      r_user  <= 1'b0;
      r_reg   <= 8'h00;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_user  <= w_user_nxt;
      if (w_cnt_clr)        r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      if (w_load) begin
        r_reg  <= r_user ? bus.usr_reg  : w_rom[15:8];
        r_data <= r_user ? bus.usr_data : w_rom[7:0];
      end
    end
  end

  assign bus.i2c_slave_addr = SLAVE_ADDR;
  assign bus.i2c_register   = r_reg;
  assign bus.i2c_data       = r_data;
  assign bus.i2c_enable     = w_enable;
  assign bus.usr_ack        = w_ack;
  assign o_busy      = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign o_done      = (r_state == S_DONE);
  assign o_error     = (r_state == S_ERROR);
  assign o_entry_idx = r_idx;

endmodule

// File: tb/tb_audio_codec_cfg_seq.sv
module tb_audio_codec_cfg_seq;

  localparam int STARTUP = 1000;
  localparam int ENG_LOW = 20;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] entry_idx;

  audio_codec_cfg_seq_if bus ();

  audio_codec_cfg_seq dut (
    .i_sys_clk   (clk),
    .i_reset     (rst),
    .i_start     (start),
    .bus         (bus),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error),
    .o_entry_idx (entry_idx)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int eng_mode = 0;        // 0 normal, 1 never drops free, 2 free stuck low
  int free_rise_cyc = 0;
  int ack_cnt = 0;
  int en_double = 0;
  int addr_bad = 0;
  logic prev_en = 1'b0;

  logic [7:0] exp_reg [6] = '{8'h1E, 8'h0C, 8'h0E, 8'h10, 8'h0A, 8'h12};
  logic [7:0] exp_dat [6] = '{8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Engine model: free drops on the enable and returns ENG_LOW cycles later.
  initial begin
    bus.i2c_free = 1'b1;
    forever begin
      @(negedge clk);
      if (eng_mode == 2) bus.i2c_free = 1'b0;
      else if (eng_mode == 0 && bus.i2c_enable) begin
        bus.i2c_free = 1'b0;
        repeat (ENG_LOW) @(negedge clk);
        if (eng_mode == 2) bus.i2c_free = 1'b0;
        else begin
          bus.i2c_free  = 1'b1;
          free_rise_cyc = cyc;
        end
      end else begin
        if (!bus.i2c_free) free_rise_cyc = cyc;
        bus.i2c_free = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.i2c_enable && prev_en) en_double++;
      prev_en = bus.i2c_enable;
      if (bus.usr_ack) ack_cnt++;
      if (bus.i2c_slave_addr !== 8'h35) addr_bad++;
    end
  end

  task automatic wait_enable(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.i2c_enable) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.usr_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_entry(input string tag, input int k);
    check_val({tag, "_reg"}, bus.i2c_register, exp_reg[k]);
    check_val({tag, "_dat"}, bus.i2c_data, exp_dat[k]);
    check_val({tag, "_idx"}, entry_idx, k);
  endtask

  // Expects table entries k0..5, then DONE with busy low.
  task automatic run_table(input string tag, input int k0, input int start_at);
    bit ok;
    for (int k = k0; k < 6; k++) begin
      wait_enable(1200, ok);
      check_val({tag, "_en_seen"}, ok, 1);
      if (!ok) return;
      check_entry(tag, k);
      if (k > k0) check_val({tag, "_spacing"}, cyc - free_rise_cyc, 10);
      if (k == start_at) pulse_start();
    end
    wait_done(100, ok);
    check_val({tag, "_done"}, ok, 1);
    check_val({tag, "_busy_in_done"}, busy, 0);
  endtask

  task automatic quiet_watch(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.i2c_enable) seen++;
    end
    check_val({tag, "_no_extra_en"}, seen, 0);
  endtask

  task automatic serve_user(input string tag, input logic [7:0] r, input logic [7:0] d, input int ack_base);
    bit ok;
    wait_enable(60, ok);
    check_val({tag, "_en_seen"}, ok, 1);
    check_val({tag, "_reg"}, bus.i2c_register, r);
    check_val({tag, "_dat"}, bus.i2c_data, d);
    wait_ack(60, ok);
    check_val({tag, "_ack_seen"}, ok, 1);
    bus.usr_req = 1'b0;
    @(negedge clk);
    check_val({tag, "_done_after"}, done, 1);
    check_val({tag, "_busy_after"}, busy, 0);
    quiet_watch(tag, 20);
    check_val({tag, "_ack_once"}, ack_cnt, ack_base + 1);
  endtask

  initial begin
    bit ok;
    int r_cyc;
    int t_en;
    int ack_base;

    rst = 1'b1;
    start = 1'b0;
    bus.usr_req  = 1'b0;
    bus.usr_reg  = 8'h00;
    bus.usr_data = 8'h00;

    // reset values
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 1);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_idx", entry_idx, 0);
    check_val("rst_en", bus.i2c_enable, 0);
    check_val("rst_reg", bus.i2c_register, 0);
    check_val("rst_dat", bus.i2c_data, 0);
    check_val("rst_ack", bus.usr_ack, 0);
    check_val("rst_addr", bus.i2c_slave_addr, 8'h35);

    // power-up table walk; a start mid-table must be ignored
    rst = 1'b0;
    r_cyc = cyc;
    wait_enable(1200, ok);
    check_val("init_en0_seen", ok, 1);
    check_val("init_first_latency", cyc - r_cyc, STARTUP + 1);
    check_entry("init_e0", 0);
    run_table("init", 1, 1);
    quiet_watch("init", 30);

    // runtime user write from DONE
    ack_base = ack_cnt;
    bus.usr_reg  = 8'h0A;
    bus.usr_data = 8'h08;
    bus.usr_req  = 1'b1;
    serve_user("usr", 8'h0A, 8'h08, ack_base);

    // engine never accepts: ack timeout into sticky ERROR
    eng_mode = 1;
    pulse_start();
    wait_enable(1200, ok);
    check_val("tmo_en_seen", ok, 1);
    check_entry("tmo_e0", 0);
    t_en = cyc;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (error) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("tmo_err_seen", ok, 1);
    check_val("tmo_err_latency", cyc - t_en, 16);
    quiet_watch("tmo", 40);
    check_val("tmo_err_sticky", error, 1);
    check_val("tmo_busy", busy, 0);
    check_val("tmo_done", done, 0);

    // start recovers and replays from entry 0
    eng_mode = 0;
    pulse_start();
    check_val("rec_err_clr", error, 0);
    check_val("rec_busy", busy, 1);
    run_table("rec", 0, -1);

    // start and usr_req together in DONE: table first, then the user write
    ack_base = ack_cnt;
    @(negedge clk);
    bus.usr_reg  = 8'h08;
    bus.usr_data = 8'h79;
    bus.usr_req  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("both_busy", busy, 1);
    check_val("both_done", done, 0);
    run_table("both", 0, -1);
    check_val("both_no_early_ack", ack_cnt, ack_base);
    serve_user("both_usr", 8'h08, 8'h79, ack_base);

    // reset during entry 3 with free low, then free held low past the delay
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      wait_enable(1200, ok);
      check_val("mid_en_seen", ok, 1);
      check_entry("mid", k);
    end
    repeat (5) @(negedge clk);
    eng_mode = 2;
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_busy", busy, 1);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_error", error, 0);
    check_val("mid_rst_idx", entry_idx, 0);
    check_val("mid_rst_en", bus.i2c_enable, 0);
    check_val("mid_rst_reg", bus.i2c_register, 0);
    check_val("mid_rst_dat", bus.i2c_data, 0);
    check_val("mid_rst_ack", bus.usr_ack, 0);
    rst = 1'b0;
    quiet_watch("mid_hold", 1100);
    check_val("mid_hold_busy", busy, 1);
    eng_mode = 0;
    wait_enable(10, ok);
    check_val("mid_en0_seen", ok, 1);
    check_val("mid_en0_after_free", cyc - free_rise_cyc, 1);
    check_entry("mid_e0", 0);
    run_table("mid", 1, -1);

    check_val("enable_one_cycle", en_double, 0);
    check_val("slave_addr_const", addr_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
